// File: rtl/sha256_regbus_pkg.sv
// Shared definitions for the sha256 register region: offsets, beat counts,
// driver FSM states and helpers that map a beat number to address and data.
package sha256_regbus_pkg;

    localparam logic [3:0] SHA_REGION = 4'h4;

    localparam logic [15:0] OFF_IA = 16'h000;
    localparam logic [15:0] OFF_IB = 16'h004;
    localparam logic [15:0] OFF_IC = 16'h008;
    localparam logic [15:0] OFF_ID = 16'h00C;
    localparam logic [15:0] OFF_IE = 16'h010;
    localparam logic [15:0] OFF_IF = 16'h014;
    localparam logic [15:0] OFF_IG = 16'h018;
    localparam logic [15:0] OFF_IH = 16'h01C;
    localparam logic [15:0] OFF_OA = 16'h020;
    localparam logic [15:0] OFF_OB = 16'h024;
    localparam logic [15:0] OFF_OC = 16'h028;
    localparam logic [15:0] OFF_OD = 16'h02C;
    localparam logic [15:0] OFF_OE = 16'h030;
    localparam logic [15:0] OFF_OF = 16'h034;
    localparam logic [15:0] OFF_OG = 16'h038;
    localparam logic [15:0] OFF_OH = 16'h03C;
    localparam logic [15:0] OFF_W  = 16'h044;
    localparam logic [15:0] OFF_K  = 16'h048;

    localparam int WR_BEATS = 10;
    localparam int RD_BEATS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_SETTLE,
        ST_READ,
        ST_DONE
    } drv_state_e;

    // Beats 0..7 are input words A..H, beat 8 is W, beat 9 is K.
    function automatic logic [15:0] wr_offset(input logic [3:0] beat);
        logic [15:0] off;
        if (beat == 4'd8) off = OFF_W;
        else if (beat == 4'd9) off = OFF_K;
        else off = OFF_IA + {11'd0, beat[2:0], 2'b00};
        return off;
    endfunction

    function automatic logic [31:0] wr_word(input logic [255:0] st, input logic [31:0] w,
                                            input logic [31:0] k, input logic [3:0] beat);
        logic [31:0] word;
        word = '0;
        if (beat == 4'd8) word = w;
        else if (beat == 4'd9) word = k;
        else begin
            for (int i = 0; i < 8; i++) begin
                if (beat == 4'(i)) word = st[255-32*i -: 32];
            end
        end
        return word;
    endfunction

    function automatic logic [15:0] rd_offset(input logic [2:0] beat);
        return OFF_OA + {11'd0, beat, 2'b00};
    endfunction

endpackage

// File: rtl/sha256_rdcapture.sv
// Read-data capture: a tag shift register marks the edge at which each read
// beat's RDATA is valid, and that word is written into the packed result.
module sha256_rdcapture
    import sha256_regbus_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         rden_i,
    input  logic [31:0]  rdata_i,
    output logic [255:0] res_o,
    output logic         last_o
);

    logic [RD_LATENCY-1:0] tag_q;
    logic [RD_LATENCY-1:0] tag_d;
    logic [2:0]            idx_q;
    logic [255:0]          res_q;
    logic                  cap;

    always_comb begin
        tag_d    = tag_q << 1;
        tag_d[0] = rden_i;
    end

    assign cap    = tag_q[RD_LATENCY-1];
    assign last_o = cap && (idx_q == 3'(RD_BEATS - 1));
    assign res_o  = res_q;

    // Word 0 (A) lands in the top 32 bits, matching the job packing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_q <= '0;
            idx_q <= '0;
            res_q <= '0;
        end else begin
            tag_q <= tag_d;
            if (cap) begin
                idx_q <= last_o ? 3'd0 : idx_q + 3'd1;
                for (int i = 0; i < 8; i++) begin
                    if (idx_q == 3'(i)) res_q[255-32*i -: 32] <= rdata_i;
                end
            end
        end
    end

endmodule

// File: rtl/sha256_round_driver.sv
// Register-bus initiator: writes one SHA-256 round job into the sha256 block,
// waits a settle interval, reads the eight result words back and returns them.
module sha256_round_driver
    import sha256_regbus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR     = {SHA_REGION, 12'h000},
    parameter int          SETTLE_CYCLES = 2,
    parameter int          RD_LATENCY    = 1
) (
    input  logic         ACLK,
    input  logic         ARST,
    input  logic         JOB_VALID,
    output logic         JOB_READY,
    input  logic [255:0] JOB_STATE,
    input  logic [31:0]  JOB_W,
    input  logic [31:0]  JOB_K,
    output logic         RES_VALID,
    input  logic         RES_READY,
    output logic [255:0] RES_STATE,
    output logic         BUSY,
    output logic [15:0]  WRADDR,
    output logic [3:0]   BYTEEN,
    output logic         WREN,
    output logic [31:0]  WDATA,
    output logic [15:0]  RDADDR,
    output logic         RDEN,
    input  logic [31:0]  RDATA
);

    drv_state_e    state_q;
    logic [3:0]    beat_q;
    logic [3:0]    settle_q;
    logic [255:0]  job_q;
    logic [31:0]   w_q;
    logic [31:0]   k_q;
    logic          job_ready_q;
    logic          busy_q;
    logic          res_valid_q;
    logic [15:0]   wraddr_q;
    logic [3:0]    byteen_q;
    logic          wren_q;
    logic [31:0]   wdata_q;
    logic [15:0]   rdaddr_q;
    logic          rden_q;
    logic          last_cap;

    // Job and result ports use valid/ready: a transfer happens on the edge
    // where both are high; the offering side holds its payload until then.
    // Bus outputs are registered for the beat issued in the following cycle.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            settle_q    <= '0;
            job_q       <= '0;
            w_q         <= '0;
            k_q         <= '0;
            job_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            wraddr_q    <= '0;
            byteen_q    <= '0;
            wren_q      <= 1'b0;
            wdata_q     <= '0;
            rdaddr_q    <= '0;
            rden_q      <= 1'b0;
        end else begin
            wren_q   <= 1'b0;
            byteen_q <= '0;
            wraddr_q <= '0;
            wdata_q  <= '0;
            rden_q   <= 1'b0;
            rdaddr_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    job_ready_q <= 1'b1;
                    if (JOB_VALID && job_ready_q) begin
                        job_q       <= JOB_STATE;
                        w_q         <= JOB_W;
                        k_q         <= JOB_K;
                        job_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        beat_q      <= '0;
                        state_q     <= ST_WRITE;
                        wren_q      <= 1'b1;
                        byteen_q    <= 4'hF;
                        wraddr_q    <= BASE_ADDR | wr_offset(4'd0);
                        wdata_q     <= wr_word(JOB_STATE, JOB_W, JOB_K, 4'd0);
                    end
                end
                ST_WRITE: begin
                    if (beat_q == 4'(WR_BEATS - 1)) begin
                        beat_q   <= '0;
                        settle_q <= '0;
                        if (SETTLE_CYCLES == 0) begin
                            state_q  <= ST_READ;
                            rden_q   <= 1'b1;
                            rdaddr_q <= BASE_ADDR | rd_offset(3'd0);
                        end else begin
                            state_q <= ST_SETTLE;
                        end
                    end else begin
                        beat_q   <= beat_q + 4'd1;
                        wren_q   <= 1'b1;
                        byteen_q <= 4'hF;
                        wraddr_q <= BASE_ADDR | wr_offset(beat_q + 4'd1);
                        wdata_q  <= wr_word(job_q, w_q, k_q, beat_q + 4'd1);
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == 4'(SETTLE_CYCLES - 1)) begin
                        state_q  <= ST_READ;
                        rden_q   <= 1'b1;
                        rdaddr_q <= BASE_ADDR | rd_offset(3'd0);
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                ST_READ: begin
                    // beat_q parks at RD_BEATS while the last captures drain.
                    if (beat_q < 4'(RD_BEATS - 1)) begin
                        beat_q   <= beat_q + 4'd1;
                        rden_q   <= 1'b1;
                        rdaddr_q <= BASE_ADDR | rd_offset(beat_q[2:0] + 3'd1);
                    end else if (beat_q == 4'(RD_BEATS - 1)) begin
                        beat_q <= 4'(RD_BEATS);
                    end
                    if (last_cap) begin
                        state_q     <= ST_DONE;
                        res_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (RES_READY) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        job_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    sha256_rdcapture #(
        .RD_LATENCY(RD_LATENCY)
    ) u_rdcapture (
        .clk_i  (ACLK),
        .rst_i  (ARST),
        .rden_i (rden_q),
        .rdata_i(RDATA),
        .res_o  (RES_STATE),
        .last_o (last_cap)
    );

    assign JOB_READY = job_ready_q;
    assign RES_VALID = res_valid_q;
    assign BUSY      = busy_q;
    assign WRADDR    = wraddr_q;
    assign BYTEEN    = byteen_q;
    assign WREN      = wren_q;
    assign WDATA     = wdata_q;
    assign RDADDR    = rdaddr_q;
    assign RDEN      = rden_q;

endmodule

// File: tb/tb_sha256_round_driver.sv
// Bench for sha256_round_driver: a default instance and a RD_LATENCY=3,
// SETTLE_CYCLES=0 instance, driven from a vector table plus a reset sequence.
module tb_sha256_round_driver;

    localparam int BW = 70;

    logic aclk = 1'b0;
    logic arst;
    always #5 aclk = ~aclk;

    logic         jv [2];
    logic         jr [2];
    logic [255:0] js [2];
    logic [31:0]  jw [2];
    logic [31:0]  jk [2];
    logic         rv [2];
    logic         rr [2];
    logic [255:0] rs [2];
    logic         busy [2];
    logic [15:0]  wa [2];
    logic [3:0]   be [2];
    logic         wen [2];
    logic [31:0]  wd [2];
    logic [15:0]  ra [2];
    logic         ren [2];
    logic [31:0]  rd [2];

    int lat_cfg    [2] = '{1, 3};
    int settle_cfg [2] = '{2, 0};

    sha256_round_driver dut0 (
        .ACLK(aclk), .ARST(arst), .JOB_VALID(jv[0]), .JOB_READY(jr[0]),
        .JOB_STATE(js[0]), .JOB_W(jw[0]), .JOB_K(jk[0]), .RES_VALID(rv[0]),
        .RES_READY(rr[0]), .RES_STATE(rs[0]), .BUSY(busy[0]), .WRADDR(wa[0]),
        .BYTEEN(be[0]), .WREN(wen[0]), .WDATA(wd[0]), .RDADDR(ra[0]),
        .RDEN(ren[0]), .RDATA(rd[0])
    );

    sha256_round_driver #(.SETTLE_CYCLES(0), .RD_LATENCY(3)) dut1 (
        .ACLK(aclk), .ARST(arst), .JOB_VALID(jv[1]), .JOB_READY(jr[1]),
        .JOB_STATE(js[1]), .JOB_W(jw[1]), .JOB_K(jk[1]), .RES_VALID(rv[1]),
        .RES_READY(rr[1]), .RES_STATE(rs[1]), .BUSY(busy[1]), .WRADDR(wa[1]),
        .BYTEEN(be[1]), .WREN(wen[1]), .WDATA(wd[1]), .RDADDR(ra[1]),
        .RDEN(ren[1]), .RDATA(rd[1])
    );

    // Responder: read i returns resp_base + i, valid only at the capture edge.
    logic [31:0] resp_base [2];
    logic [31:0] pipe_d [2][4];
    logic        pipe_v [2][4];

    always @(posedge aclk) begin
        for (int u = 0; u < 2; u++) begin
            pipe_v[u][0] <= ren[u];
            pipe_d[u][0] <= resp_base[u] + 32'((ra[u] - 16'h4020) >> 2);
            for (int s = 1; s < 4; s++) begin
                pipe_v[u][s] <= pipe_v[u][s-1];
                pipe_d[u][s] <= pipe_d[u][s-1];
            end
        end
    end

    assign rd[0] = pipe_v[0][0] ? pipe_d[0][0] : 32'hDEAD_BEEF;
    assign rd[1] = pipe_v[1][2] ? pipe_d[1][2] : 32'hDEAD_BEEF;

    int checks = 0;
    int errors = 0;
    logic [BW-1:0] exp_q [$];
    logic [15:0] exp_wa [10];
    logic [15:0] exp_ra [8];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] bus_of(input int u);
        return {wen[u], be[u], wa[u], wd[u], ren[u], ra[u]};
    endfunction

    typedef struct {
        int           u;
        logic [255:0] st;
        logic [31:0]  w;
        logic [31:0]  k;
        logic [31:0]  base;
        int           hold;
        bit           pulse;
        logic [255:0] res;
    } vec_t;

    vec_t vecs [5];

    task automatic run_job(input vec_t v);
        int n;
        int u;
        int exp_lat;
        logic [31:0] word;
        logic [BW-1:0] e;
        u = v.u;
        exp_lat = 18 + settle_cfg[u] + lat_cfg[u];
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            word = (i < 8) ? v.st[255-32*i -: 32] : ((i == 8) ? v.w : v.k);
            exp_q.push_back({1'b1, 4'hF, exp_wa[i], word, 1'b0, 16'h0});
        end
        for (int i = 0; i < settle_cfg[u]; i++) exp_q.push_back('0);
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 4'h0, 16'h0, 32'h0, 1'b1, exp_ra[i]});

        resp_base[u] = v.base;
        rr[u] = (v.hold == 0);
        n = 0;
        while (!jr[u] && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("job_ready_idle", jr[u], 1);
        js[u] = v.st;
        jw[u] = v.w;
        jk[u] = v.k;
        jv[u] = 1'b1;
        @(posedge aclk);
        n = 0;
        @(negedge aclk);
        jv[u] = 1'b0;
        js[u] = ~v.st;
        jw[u] = ~v.w;
        jk[u] = ~v.k;
        while (!rv[u] && n < 60) begin
            e = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            check($sformatf("bus_u%0d_n%0d", u, n), bus_of(u), e);
            if (n == 5) check("busy_mid_job", {busy[u], jr[u]}, 2'b10);
            jv[u] = v.pulse && (n == 3 || n == 14);
            @(posedge aclk);
            n++;
            @(negedge aclk);
        end
        jv[u] = 1'b0;
        check("res_valid_latency", n, exp_lat);
        check("bus_idle_done", bus_of(u), '0);
        check("queue_drained", exp_q.size(), 0);

        for (int c = 0; c < v.hold; c++) begin
            check("res_hold", {rv[u], jr[u], rs[u]}, {1'b1, 1'b0, v.res});
            @(negedge aclk);
        end
        rr[u] = 1'b1;
        check("res_state", {rv[u], rs[u]}, {1'b1, v.res});
        @(posedge aclk);
        @(negedge aclk);
        rr[u] = 1'b0;
        check("after_handshake", {rv[u], jr[u], busy[u]}, 3'b010);
    endtask

    task automatic reset_mid_read();
        int n;
        resp_base[0] = 32'h5000;
        rr[0] = 1'b0;
        js[0] = {8{32'h1234_5678}};
        jw[0] = 32'h1;
        jk[0] = 32'h2;
        n = 0;
        while (!jr[0] && n < 50) begin
            @(negedge aclk);
            n++;
        end
        jv[0] = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        jv[0] = 1'b0;
        n = 0;
        while (!(ren[0] && ra[0] == 16'h4030) && n < 40) begin
            @(negedge aclk);
            n++;
        end
        check("reached_read_beat4", {ren[0], ra[0]}, {1'b1, 16'h4030});
        arst = 1'b1;
        #1;
        check("strobes_drop_on_reset", {wen[0], ren[0], ra[0], rv[0], busy[0], jr[0]}, '0);
        repeat (3) @(negedge aclk);
        check("held_in_reset", {jr[0], rv[0], rs[0]}, '0);
        arst = 1'b0;
        n = 0;
        repeat (25) begin
            @(negedge aclk);
            if (rv[0] || busy[0]) n++;
        end
        check("no_result_after_reset", n, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_wa = '{16'h4000, 16'h4004, 16'h4008, 16'h400C, 16'h4010,
                   16'h4014, 16'h4018, 16'h401C, 16'h4044, 16'h4048};
        exp_ra = '{16'h4020, 16'h4024, 16'h4028, 16'h402C,
                   16'h4030, 16'h4034, 16'h4038, 16'h403C};

        vecs[0] = '{0, 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008,
                    32'h9, 32'hA, 32'h1000, 5, 1'b0,
                    256'h00001000_00001001_00001002_00001003_00001004_00001005_00001006_00001007};
        vecs[1] = '{0, 256'h6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19,
                    32'h61626380, 32'h428A2F98, 32'hA5A50000, 0, 1'b0,
                    256'hA5A50000_A5A50001_A5A50002_A5A50003_A5A50004_A5A50005_A5A50006_A5A50007};
        vecs[2] = '{1, 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008,
                    32'h9, 32'hA, 32'h1000, 2, 1'b0,
                    256'h00001000_00001001_00001002_00001003_00001004_00001005_00001006_00001007};
        vecs[3] = '{0, 256'hFFFFFFFF_00000000_80000001_7FFFFFFE_DEADBEEF_CAFEF00D_01234567_89ABCDEF,
                    32'hFFFFFFFF, 32'h00000000, 32'h2000, 1, 1'b1,
                    256'h00002000_00002001_00002002_00002003_00002004_00002005_00002006_00002007};
        vecs[4] = '{1, 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888,
                    32'hC67178F2, 32'hBEF9A3F7, 32'hFFFFFFF8, 0, 1'b1,
                    256'hFFFFFFF8_FFFFFFF9_FFFFFFFA_FFFFFFFB_FFFFFFFC_FFFFFFFD_FFFFFFFE_FFFFFFFF};

        arst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            jv[u] = 1'b0;
            rr[u] = 1'b0;
            js[u] = '0;
            jw[u] = '0;
            jk[u] = '0;
            resp_base[u] = '0;
        end
        repeat (3) @(negedge aclk);
        for (int u = 0; u < 2; u++) begin
            check("reset_bus", bus_of(u), '0);
            check("reset_status", {jr[u], rv[u], busy[u]}, 3'b000);
            check("reset_res_state", rs[u], '0);
        end
        arst = 1'b0;

        for (int i = 0; i < 5; i++) run_job(vecs[i]);
        reset_mid_read();
        run_job(vecs[0]);
        run_job(vecs[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_round_driver.md
Name: sha256_round_driver

Overview:
Register-bus initiator that drives one SHA-256 round job into the sha256 register block and reads the result back. It accepts a job of eight state words plus W and K over a valid/ready handshake. It then issues the write beats, waits a settle interval, and issues eight read beats while capturing RDATA at a fixed latency. The 256-bit round result is returned over a valid/ready handshake. It sits between a hashing sequencer and the register-bus responder, in the 0x4xxx region.

Parameters:
BASE_ADDR, 16'h4000, region base; bits [15:12] select the sha256 register region.
SETTLE_CYCLES, 2, idle cycles between the last write beat and the first read beat; legal range 0..15.
RD_LATENCY, 1, clock edges from the edge sampling RDEN to the edge at which RDATA is valid to capture; legal range 1..4.

Ports:
ACLK  in  1  clock.
ARST  in  1  reset; asynchronous, active-high.
JOB_VALID  in  1  job offered.
JOB_READY  out  1  high only in IDLE.
JOB_STATE  in  256  input words A..H; A occupies [255:224] and H occupies [31:0].
JOB_W  in  32  message schedule word.
JOB_K  in  32  round constant.
RES_VALID  out  1  result available.
RES_READY  in  1  result consumed.
RES_STATE  out  256  output words A..H, packed like JOB_STATE.
BUSY  out  1  high whenever not in IDLE.
WRADDR  out  16  write byte address.
BYTEEN  out  4  byte enables.
WREN  out  1  write strobe.
WDATA  out  32  write data.
RDADDR  out  16  read byte address.
RDEN  out  1  read strobe.
RDATA  in  32  read data from the responder.

Behaviour:
- Reset (async, active-high): state=IDLE. All bus outputs are 0. RES_VALID=0 and RES_STATE=0. JOB_READY=0 while ARST is high. BUSY=0.
- Reset asserted mid-job: the job is discarded and the strobes drop immediately. No partial result is ever presented.
- FSM states are IDLE, WRITE, SETTLE, READ, DONE.
- IDLE:
  - JOB_READY=1.
  - On JOB_VALID&&JOB_READY, latch JOB_STATE, JOB_W and JOB_K, then go to WRITE.
- WRITE: 10 beats, one per cycle, with WREN=1 and BYTEEN=4'hF.
  - Beat order: A..H at offsets 0x000,0x004,...,0x01C, then W at 0x044, then K at 0x048.
  - WRADDR = BASE_ADDR | offset.
  - After beat 9, go to SETTLE, or directly to READ if SETTLE_CYCLES=0.
- SETTLE: count SETTLE_CYCLES cycles with no strobes, then go to READ.
- READ: 8 beats, one per cycle, with RDEN=1 and RDADDR = BASE_ADDR | (0x020+4*i) for i=0..7, i.e. oA..oH.
  - Capture uses a RD_LATENCY-deep tag pipeline. RDATA is sampled into word i of RES_STATE at the edge RD_LATENCY edges after the edge that sampled read beat i.
  - After the last capture, go to DONE.
- DONE:
  - RES_VALID=1.
  - RES_STATE is held stable until RES_VALID&&RES_READY.
  - On that handshake edge, RES_VALID falls and the FSM returns to IDLE. JOB_READY rises on the following cycle; there is no same-cycle accept.
- When a strobe is low, its address and data outputs are driven to 0. At most one of WREN and RDEN is high in any cycle.
- Latency: RES_VALID rises at edge 18+SETTLE_CYCLES+RD_LATENCY after the accept edge. With default parameters this is edge 21.
- JOB_VALID outside IDLE is ignored, and the job inputs are not re-sampled.
- RES_READY held high in advance completes the handshake on the first DONE cycle.
- Counters wrap only at their programmed terminal counts; there is no free-running wrap.

Decomposition:
- Shared package sha256_regbus_pkg holds:
  - the region nibble 4'h4;
  - word offsets IA..IH (0x000-0x01C), OA..OH (0x020-0x03C), W (0x044) and K (0x048);
  - the FSM state enum;
  - beat-count constants 10 and 8.
- One sub-module: sha256_rdcapture. It holds the RD_LATENCY tag shift register, the word index, and the RES_STATE capture registers with write-enable.

Test Plan:
- Reset then job A..H=1..8, W=9, K=0xA with defaults -> WRADDR sequence 0x4000..0x401C,0x4044,0x4048 with WDATA 1..10 and BYTEEN=F; RDADDR 0x4020..0x403C; RES_VALID at edge 21.
- Responder model returning 0x1000+i on read i, RES_READY held low 5 cycles -> RES_STATE = {0x1000..0x1007}, stable for those 5 cycles; JOB_READY=1 only the cycle after the handshake.
- RD_LATENCY=3, SETTLE_CYCLES=0 -> first RDEN in the cycle after the last write; captures shifted by 3 edges; RES_VALID at edge 21.
- JOB_VALID pulsed with new data during WRITE and READ -> ignored; bus traffic and result match only the first job.
- ARST asserted during READ beat 4 -> RDEN/WREN drop immediately, RES_VALID never rises, IDLE after release; next job completes correctly.
